// File: rtl/jtag_ocimem_ctrl.sv
// On-chip debug RAM shared between the JTAG debug wrapper and the CPU monitor (Avalon-MM).
// JTAG commands always win; Avalon accesses stall until the JTAG side is quiet.
module jtag_ocimem_ctrl #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W:0]   avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic [3:0]        avs_byteenable,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [31:0]       MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic              resetrequest
);

   typedef enum logic [1:0] {StIdle, StJop, StJrd, StAvrd} state_e;

   localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

   state_e            state;
   logic [31:0]       mem [2**ADDR_W];
   logic              pend;
   logic              op_wr;
   logic              op_inc;
   logic [31:0]       op_wdata;
   logic [31:0]       ram_q;
   logic              any_take;
   logic              outstanding;
   logic              ctrl_sel;
   logic              wr_accept;
   logic [31:0]       ctrl_word;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              unused_jdo;

   assign any_take    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   // JRD only touches MonDReg, so a new pulse may already land while it finishes.
   assign outstanding = pend | (state == StJop);
   assign ctrl_sel    = avs_address[ADDR_W];
   assign ctrl_word   = {29'b0, resetrequest, monitor_error, monitor_ready};
   assign unused_jdo  = ^{jdo[37:35], jdo[2:0]};

   assign avs_waitrequest = reset | any_take | pend | (state == StJop) | (state == StJrd) |
                            (avs_read & (state != StAvrd));
   assign wr_accept       = avs_write & ~avs_read & ~avs_waitrequest;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = MonAReg;
      mem_wdata = op_wdata;
      mem_be    = 4'hF;
      if (!reset && state == StJop && op_wr) begin
         mem_we = 1'b1;
      end else if (wr_accept && !ctrl_sel) begin
         mem_we    = 1'b1;
         mem_waddr = avs_address[ADDR_W-1:0];
         mem_wdata = avs_writedata;
         mem_be    = avs_byteenable;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= StIdle;
         pend          <= 1'b0;
         op_wr         <= 1'b0;
         op_inc        <= 1'b0;
         op_wdata      <= 32'b0;
         ram_q         <= 32'b0;
         avs_readdata  <= 32'b0;
         MonDReg       <= 32'b0;
         MonAReg       <= '0;
         monitor_ready <= 1'b0;
         monitor_error <= 1'b0;
         resetrequest  <= 1'b0;
      end else begin
         if (wr_accept && ctrl_sel) begin
            if (avs_writedata[0]) monitor_ready <= 1'b1;
            if (avs_writedata[1]) monitor_error <= 1'b1;
         end

         if (take_action_ocimem_a && !outstanding) begin
            MonAReg      <= jdo[ADDR_W+25:26];
            resetrequest <= jdo[17];
            if (jdo[25]) monitor_ready <= 1'b0;
            if (jdo[24]) monitor_error <= 1'b0;
            pend   <= 1'b1;
            op_wr  <= 1'b0;
            op_inc <= 1'b0;
         end else if (take_action_ocimem_b && !outstanding) begin
            pend     <= 1'b1;
            op_wr    <= 1'b1;
            op_inc   <= 1'b1;
            op_wdata <= jdo[34:3];
         end else if (take_no_action_ocimem_a && !outstanding) begin
            pend   <= 1'b1;
            op_wr  <= 1'b0;
            op_inc <= 1'b1;
         end

         case (state)
            StIdle: begin
               if (pend) begin
                  pend  <= 1'b0;
                  state <= StJop;
               end else if (avs_read && !any_take) begin
                  avs_readdata <= ctrl_sel ? ctrl_word : mem[avs_address[ADDR_W-1:0]];
                  state        <= StAvrd;
               end
            end
            StJop: begin
               if (op_inc) MonAReg <= MonAReg + AddrOne;
               if (op_wr) begin
                  state <= StIdle;
               end else begin
                  ram_q <= mem[MonAReg];
                  state <= StJrd;
               end
            end
            StJrd: begin
               MonDReg <= ram_q;
               state   <= StIdle;
            end
            StAvrd: state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/jtag_ocimem_ctrl.md
Name: jtag_ocimem_ctrl

Overview:
- Sits on the clk side, directly downstream of the JTAG debug-module wrapper.
- Consumes jdo and the ocimem take_action/take_no_action pulses; in return produces MonDReg, monitor_ready and monitor_error back to the wrapper.
- Owns the 32-bit on-chip debug RAM. The debugger reaches it through the JTAG commands; the CPU's debug monitor reaches it through an Avalon-MM slave.
- Arbitrates between the two sides; JTAG has priority.

Parameters:
- ADDR_W, 8, word-address width of debug RAM (2^ADDR_W x 32 bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  JTAG data word from the wrapper; stable whenever a take pulse is high.
- take_action_ocimem_a  in  1  one-cycle pulse: load address/control.
- take_action_ocimem_b  in  1  one-cycle pulse: write data word.
- take_no_action_ocimem_a  in  1  one-cycle pulse: read next word.
- avs_address  in  ADDR_W+1  MSB=1 selects the control register; MSB=0 selects RAM word [ADDR_W-1:0].
- avs_read  in  1  Avalon read request.
- avs_write  in  1  Avalon write request.
- avs_writedata  in  32  Avalon write data.
- avs_byteenable  in  4  byte lanes for RAM writes.
- avs_readdata  out  32  Avalon read data.
- avs_waitrequest  out  1  Avalon stall.
- MonDReg  out  32  data returned to the wrapper.
- MonAReg  out  ADDR_W  current JTAG word address.
- monitor_ready  out  1  CPU monitor done flag.
- monitor_error  out  1  CPU monitor error flag.
- resetrequest  out  1  debugger-requested CPU reset.

Behaviour:
- Reset (sync, active-high): the following all go to 0:
  - MonAReg, MonDReg, avs_readdata.
  - monitor_ready, monitor_error, resetrequest.
  - Any pending JTAG op; the FSM goes to IDLE.
  - avs_waitrequest=1 while reset is high.
  - RAM contents are NOT cleared. Reset mid-operation aborts it and drops it.
- Take pulses are mutually exclusive. Minimum spacing is 3 clk. A pulse arriving while a JTAG op is outstanding is ignored; the bench flags this as an assertion failure.
- take_action_ocimem_a (edge N):
  - MonAReg<=jdo[ADDR_W+25:26].
  - resetrequest<=jdo[17].
  - jdo[25]=1 clears monitor_ready; jdo[24]=1 clears monitor_error.
  - Queues a JTAG read of RAM[new MonAReg]; MonAReg is not incremented.
- take_action_ocimem_b: queues a write of jdo[34:3] (all bytes) to RAM[MonAReg], then MonAReg+1.
- take_no_action_ocimem_a: queues a read of RAM[MonAReg] into MonDReg, then MonAReg+1.
- MonAReg increment wraps 2^ADDR_W-1 -> 0.
- FSM states: IDLE, JOP, JRD, AVRD.
  - IDLE + JTAG op pending -> JOP: RAM access issued in cycle N+1. A read goes to JRD; a write goes to IDLE.
  - JRD: MonDReg<=RAM q; visible at cycle N+3. -> IDLE.
  - IDLE, no JTAG pulse/pending, avs_read to RAM -> AVRD: RAM read issued, waitrequest=1. Next cycle avs_readdata<=q, waitrequest=0 (2-cycle read). -> IDLE.
  - Avalon RAM write in IDLE with no JTAG pulse/pending: accepted in 1 cycle, waitrequest=0, byteenable applied.
- avs_waitrequest=1 when any of the following holds:
  - a take pulse is high this cycle;
  - a JTAG op is pending;
  - state is JOP or JRD;
  - the first cycle of an Avalon read.
  - Consequence: a CPU set of monitor_ready and a JTAG clear can never take effect in the same cycle; the CPU write stalls and lands afterwards, so the set wins.
- Control register (MSB=1):
  - Write: bit0=1 sets monitor_ready; bit1=1 sets monitor_error; 0 bits have no effect.
  - Read (also 2-cycle): returns {29'b0, resetrequest, monitor_error, monitor_ready}.
- avs_read and avs_write asserted together is illegal; read takes precedence.
- avs_readdata holds its last value until the next read completes.

Test Plan:
- Reset: hold reset 2 clk, release -> all outputs 0, waitrequest 0 next cycle; RAM word 5 written before reset still reads its old value.
- Address and read: CPU writes RAM[0x10]=0xCAFE_F00D; pulse take_action_ocimem_a with jdo[33:26]=0x10 -> MonAReg=0x10, MonDReg=0xCAFEF00D at N+3.
- Write and increment: MonAReg=0xFF, take_action_ocimem_b with jdo[34:3]=0x1234_5678 -> RAM[0xFF]=0x12345678, MonAReg=0x00 (wrap); a CPU read of 0xFF returns 0x12345678.
- Handshake: jdo[25]=1,jdo[24]=1 clears both flags; CPU writes ctrl=0x3 -> monitor_ready=1, monitor_error=1; ctrl read returns 0x3.
- Collision: avs_write to ctrl in the same cycle as take_action_ocimem_a with jdo[25]=1 -> waitrequest held until the JTAG op completes; final monitor_ready=1.
- Reset mid-op: reset asserted in JRD -> MonDReg=0, no late update, FSM IDLE.
